// File: rtl/synaptic_scheduler_if.sv
// Synaptic scheduler memory/event bus: spike-buffer read port, weight-memory
// read port and the outgoing synaptic event handshake.
// master = scheduler side, slave = memories / event consumer side.
interface synaptic_scheduler_if #(
  parameter int N_PRE  = 4,
  parameter int N_POST = 4,
  parameter int W_W    = 2
);
  localparam int PRE_W  = $clog2(N_PRE);
  localparam int POST_W = $clog2(N_POST);
  localparam int ADDR_W = $clog2(N_PRE * N_POST);

  logic              ibuf_rd_en_o;
  logic [PRE_W-1:0]  ibuf_rd_addr_o;
  logic              ibuf_data_i;
  logic              wmem_rd_en_o;
  logic [ADDR_W-1:0] wmem_rd_addr_o;
  logic [W_W-1:0]    wmem_data_i;
  logic              syn_valid_o;
  logic              syn_ready_i;
  logic [POST_W-1:0] syn_post_o;
  logic [W_W-1:0]    syn_weight_o;

  modport master (
    output ibuf_rd_en_o, ibuf_rd_addr_o,
    input  ibuf_data_i,
    output wmem_rd_en_o, wmem_rd_addr_o,
    input  wmem_data_i,
    output syn_valid_o,
    input  syn_ready_i,
    output syn_post_o, syn_weight_o
  );

  modport slave (
    input  ibuf_rd_en_o, ibuf_rd_addr_o,
    output ibuf_data_i,
    input  wmem_rd_en_o, wmem_rd_addr_o,
    output wmem_data_i,
    input  syn_valid_o,
    output syn_ready_i,
    input  syn_post_o, syn_weight_o
  );
endinterface

// File: rtl/synaptic_scheduler.sv
// Synaptic event scheduler: every timestep tick it scans the presynaptic
// spike buffer and, for each spiking neuron, reads its weight row and emits
// one (post index, weight) event per postsynaptic neuron.
// Optional feature: define SYN_SCHED_ZERO_SKIP_EN to suppress events whose
// weight is zero (the scan then moves straight on to the next post index).
module synaptic_scheduler #(
  parameter int N_PRE       = 4,
  parameter int N_POST      = 4,
  parameter int W_W         = 2,
  parameter int TICK_PERIOD = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 ovr_clr_i,
  output logic                 tick_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overrun_o,
  synaptic_scheduler_if.master bus
);
  localparam int PRE_W  = $clog2(N_PRE);
  localparam int POST_W = $clog2(N_POST);
  localparam int ADDR_W = $clog2(N_PRE * N_POST);
  localparam int CNT_W  = $clog2(TICK_PERIOD);

  localparam logic [PRE_W-1:0]  LAST_PRE  = PRE_W'(N_PRE - 1);
  localparam logic [POST_W-1:0] LAST_POST = POST_W'(N_POST - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TICK_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SPK_RD,
    SPK_CHK,
    W_RD,
    W_CAP,
    EMIT
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [CNT_W-1:0]    r_cnt;
  logic [PRE_W-1:0]    r_pre;
  logic [PRE_W-1:0]    w_nextPre;
  logic [POST_W-1:0]   r_post;
  logic [POST_W-1:0]   w_nextPost;
  logic [POST_W-1:0]   r_synPost;
  logic [W_W-1:0]      r_synWeight;
  logic                r_done;
  logic                r_overrun;

  logic                w_tick;
  logic                w_busy;
  logic                w_capture;
  logic                w_postAdv;
  logic                w_preAdv;
  logic                w_ibufRdEn;
  logic [PRE_W-1:0]    w_ibufAddr;
  logic                w_wmemRdEn;
  logic [ADDR_W-1:0]   w_wmemAddr;
  logic                w_synValid;

  assign w_tick = en_i && (r_cnt == LAST_CNT);
  assign w_busy = (r_state != IDLE);

  // Timestep counter: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (!en_i || (r_cnt == LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Scan FSM next-state, index updates and read/emit strobes.
  always_comb begin
    w_nextState = r_state;
    w_nextPre   = r_pre;
    w_nextPost  = r_post;
    w_capture   = 1'b0;
    w_postAdv   = 1'b0;
    w_preAdv    = 1'b0;
    w_ibufRdEn  = 1'b0;
    w_ibufAddr  = '0;
    w_wmemRdEn  = 1'b0;
    w_wmemAddr  = '0;
    w_synValid  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_nextPre   = '0;
          w_nextPost  = '0;
          w_nextState = SPK_RD;
        end
      end
      SPK_RD: begin
        w_ibufRdEn  = 1'b1;
        w_ibufAddr  = r_pre;
        w_nextState = SPK_CHK;
      end
      SPK_CHK: begin
        if (bus.ibuf_data_i) begin
          w_nextPost  = '0;
          w_nextState = W_RD;
        end else begin
          w_preAdv = 1'b1;
        end
      end
      W_RD: begin
        w_wmemRdEn  = 1'b1;
        w_wmemAddr  = ADDR_W'(r_pre) * ADDR_W'(N_POST) + ADDR_W'(r_post);
        w_nextState = W_CAP;
      end
      W_CAP: begin
        w_capture = 1'b1;
`ifdef SYN_SCHED_ZERO_SKIP_EN
        if (bus.wmem_data_i == '0) begin
          w_postAdv = 1'b1;
        end else begin
          w_nextState = EMIT;
        end
`else
        w_nextState = EMIT;
`endif
      end
      EMIT: begin
        w_synValid = 1'b1;
        if (bus.syn_ready_i) begin
          w_postAdv = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (w_postAdv) begin
      if (r_post != LAST_POST) begin
        w_nextPost  = r_post + 1'b1;
        w_nextState = W_RD;
      end else begin
        w_preAdv = 1'b1;
      end
    end

    if (w_preAdv) begin
      if (r_pre != LAST_PRE) begin
        w_nextPre   = r_pre + 1'b1;
        w_nextState = SPK_RD;
      end else begin
        w_nextState = IDLE;
      end
    end
  end

  // FSM state and scan indices.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_post  <= '0;
    end else begin
      r_state <= w_nextState;
      r_pre   <= w_nextPre;
      r_post  <= w_nextPost;
    end
  end

  // Event payload capture; held through EMIT so backpressure sees stable data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_synPost   <= '0;
      r_synWeight <= '0;
    end else if (w_capture) begin
      r_synPost   <= r_post;
      r_synWeight <= bus.wmem_data_i;
    end
  end

  // Done pulse on return to IDLE and sticky overrun (set beats clear).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= w_busy && (w_nextState == IDLE);
      if (w_tick && w_busy) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign tick_o             = w_tick;
  assign busy_o             = w_busy;
  assign done_o             = r_done;
  assign overrun_o          = r_overrun;
  assign bus.ibuf_rd_en_o   = w_ibufRdEn;
  assign bus.ibuf_rd_addr_o = w_ibufAddr;
  assign bus.wmem_rd_en_o   = w_wmemRdEn;
  assign bus.wmem_rd_addr_o = w_wmemAddr;
  assign bus.syn_valid_o    = w_synValid;
  assign bus.syn_post_o     = r_synPost;
  assign bus.syn_weight_o   = r_synWeight;
endmodule
